// File: rtl/e_nested_assembler_pkg.sv
// Types and constants for the e_nested_assembler gather stage.
// The record types mirror those used by the inAndOut design. The eNestedSt
// width is the sum of its fields: 1 (variablea) + 7 (bob) + 2 x 5 (joe) = 18.
package e_nested_assembler_pkg;

    typedef logic [1:0] aBiggerT;

    typedef struct packed {
        logic [1:0] variablea;
    } aSt;

    typedef logic [4:0] seeSt;
    typedef logic [6:0] dSt;

    localparam int ASM_C_BEATS = 2;

    typedef struct packed {
        logic                    variablea;
        dSt                      bob;
        seeSt [ASM_C_BEATS-1:0]  joe;
    } eNestedSt;

    typedef struct packed {
        aBiggerT hdr;
    } eHeaderSt;

    typedef enum logic {
        ASM_COLLECT = 1'b0,
        ASM_OUT     = 1'b1
    } asmStateT;

    localparam int E_W = $bits(eNestedSt);
    localparam int H_W = $bits(eHeaderSt);

    // Sequence header advance, wrapping 3 -> 0.
    function automatic aBiggerT next_seq(input aBiggerT seq);
        return seq + 2'd1;
    endfunction

endpackage

// File: rtl/e_nested_assembler_collector.sv
// e_nested_collector: tracks which input beats of the current set have been
// captured (a flag, c beat count, d flag), holds the partial record, and
// reports when the set is complete including this cycle's handshakes.
// Readys depend only on registered flags and the enable input.
module e_nested_collector
    import e_nested_assembler_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     enable,
    input  logic     clear,
    input  logic     a_valid,
    output logic     a_ready,
    input  aSt       a_data,
    input  logic     c_valid,
    output logic     c_ready,
    input  seeSt     c_data,
    input  logic     d_valid,
    output logic     d_ready,
    input  dSt       d_data,
    output eNestedSt rec_next,
    output logic     done
);

    localparam logic [1:0] C_FULL = 2'(ASM_C_BEATS);

    logic       a_got_r;
    logic       d_got_r;
    logic [1:0] c_cnt_r;
    eNestedSt   rec_r;

    logic       a_fire_s;
    logic       c_fire_s;
    logic       d_fire_s;
    logic       a_got_s;
    logic       d_got_s;
    logic [1:0] c_cnt_s;
    eNestedSt   rec_s;
    logic       a_hi_unused_s;

    // Only bit 0 of the aSt field is carried into the record.
    assign a_hi_unused_s = a_data.variablea[1];

    assign a_ready  = enable && !a_got_r;
    assign c_ready  = enable && (c_cnt_r < C_FULL);
    assign d_ready  = enable && !d_got_r;

    assign a_fire_s = a_valid && a_ready;
    assign c_fire_s = c_valid && c_ready;
    assign d_fire_s = d_valid && d_ready;

    // Merge this cycle's handshakes into the flags and partial record.
    always_comb begin
        rec_s   = rec_r;
        a_got_s = a_got_r;
        d_got_s = d_got_r;
        c_cnt_s = c_cnt_r;
        if (a_fire_s) begin
            a_got_s         = 1'b1;
            rec_s.variablea = a_data.variablea[0];
        end else begin
            a_got_s         = a_got_r;
        end
        if (c_fire_s) begin
            c_cnt_s = c_cnt_r + 2'd1;
            case (c_cnt_r)
                2'd0:    rec_s.joe[0] = c_data;
                2'd1:    rec_s.joe[1] = c_data;
                default: rec_s.joe    = rec_r.joe;
            endcase
        end else begin
            c_cnt_s = c_cnt_r;
        end
        if (d_fire_s) begin
            d_got_s   = 1'b1;
            rec_s.bob = d_data;
        end else begin
            d_got_s   = d_got_r;
        end
    end

    assign rec_next = rec_s;
    assign done     = a_got_s && d_got_s && (c_cnt_s == C_FULL);

    // Collection state; a transfer out of the collector empties the set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_got_r <= 1'b0;
            d_got_r <= 1'b0;
            c_cnt_r <= 2'd0;
            rec_r   <= '0;
        end else if (clear) begin
            a_got_r <= 1'b0;
            d_got_r <= 1'b0;
            c_cnt_r <= 2'd0;
            rec_r   <= '0;
        end else begin
            a_got_r <= a_got_s;
            d_got_r <= d_got_s;
            c_cnt_r <= c_cnt_s;
            rec_r   <= rec_s;
        end
    end

endmodule

// File: rtl/e_nested_assembler.sv
// e_nested_assembler: gathers one aSt, two seeSt and one dSt beat into an
// eNestedSt record tagged with a 2-bit sequence header, presented on one
// valid/ready output.
// Optional macro E_NESTED_ASSEMBLER_OVERLAP_EN: keep collecting the next set
// while the output register holds a record (one record per 2 cycles).
// Without it the input readys are all 0 while a record is held.
module e_nested_assembler
    import e_nested_assembler_pkg::*;
#(
    parameter aBiggerT SEQ_INIT = 2'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [1:0]     a_data,
    input  logic           c_valid,
    output logic           c_ready,
    input  logic [4:0]     c_data,
    input  logic           d_valid,
    output logic           d_ready,
    input  logic [6:0]     d_data,
    output logic           e_valid,
    input  logic           e_ready,
    output logic [E_W-1:0] e_data,
    output logic [H_W-1:0] e_hdr
);

    asmStateT state_r;
    asmStateT state_s;
    eNestedSt e_data_r;
    eHeaderSt hdr_r;

    logic     enable_s;
    logic     done_s;
    logic     load_s;
    logic     consume_s;
    eNestedSt rec_next_s;

`ifdef E_NESTED_ASSEMBLER_OVERLAP_EN
    assign enable_s = 1'b1;
`else
    assign enable_s = (state_r == ASM_COLLECT);
`endif

    e_nested_collector u_collector (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable_s),
        .clear    (load_s),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (aSt'(a_data)),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .c_data   (c_data),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_data   (d_data),
        .rec_next (rec_next_s),
        .done     (done_s)
    );

    // A complete set moves to the output when it is empty or being drained.
    // Without overlap a set can only complete while the output is empty.
    assign load_s = done_s && ((state_r == ASM_COLLECT) || e_ready);

    // Next-state: output register occupancy.
    always_comb begin
        state_s   = state_r;
        consume_s = 1'b0;
        case (state_r)
            ASM_COLLECT: begin
                consume_s = 1'b0;
                if (load_s) begin
                    state_s = ASM_OUT;
                end else begin
                    state_s = ASM_COLLECT;
                end
            end
            ASM_OUT: begin
                consume_s = e_ready;
                if (e_ready && !load_s) begin
                    state_s = ASM_COLLECT;
                end else begin
                    state_s = ASM_OUT;
                end
            end
            default: begin
                consume_s = 1'b0;
                state_s   = ASM_COLLECT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ASM_COLLECT;
        end else begin
            state_r <= state_s;
        end
    end

    // Output record register, held until the next set is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_data_r <= '0;
        end else if (load_s) begin
            e_data_r <= rec_next_s;
        end else begin
            e_data_r <= e_data_r;
        end
    end

    // Sequence header advances once per consumed record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_r.hdr <= SEQ_INIT;
        end else if (consume_s) begin
            hdr_r.hdr <= next_seq(hdr_r.hdr);
        end else begin
            hdr_r.hdr <= hdr_r.hdr;
        end
    end

    assign e_valid = (state_r == ASM_OUT);
    assign e_data  = e_data_r;
    assign e_hdr   = hdr_r;

endmodule

// File: tb/tb_e_nested_assembler.sv
// Self-checking bench for e_nested_assembler. A queue-based reference model
// applies the gather rules to the driven beats; directed steps cover the
// listed scenarios, then randomized traffic runs against the model.
module tb_e_nested_assembler;

`ifdef E_NESTED_ASSEMBLER_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif
    localparam logic [1:0] SEQ = 2'd0;

    logic        clk;
    logic        rst_n;
    logic        a_valid, a_ready;
    logic [1:0]  a_data;
    logic        c_valid, c_ready;
    logic [4:0]  c_data;
    logic        d_valid, d_ready;
    logic [6:0]  d_data;
    logic        e_valid, e_ready;
    logic [17:0] e_data;
    logic [1:0]  e_hdr;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: beats gathered so far and the record on the output.
    logic        m_have_a, m_have_d;
    logic        m_a;
    logic [6:0]  m_d;
    logic [4:0]  c_beats[$];
    logic        m_out_valid;
    logic [17:0] m_out_data;
    logic [1:0]  m_hdr;

    e_nested_assembler #(.SEQ_INIT(SEQ)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .c_data  (c_data),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_data  (d_data),
        .e_valid (e_valid),
        .e_ready (e_ready),
        .e_data  (e_data),
        .e_hdr   (e_hdr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_have_a    = 1'b0;
        m_have_d    = 1'b0;
        m_a         = 1'b0;
        m_d         = 7'd0;
        c_beats.delete();
        m_out_valid = 1'b0;
        m_out_data  = 18'd0;
        m_hdr       = SEQ;
    endtask

    // Called at a negedge: check outputs, drive one cycle, advance the model.
    task automatic step(input logic av, input logic [1:0] ad, input logic cv,
                        input logic [4:0] cd, input logic dv, input logic [6:0] dd,
                        input logic er);
        logic can, ra, rc, rd, done, consume;
        can = OVL || !m_out_valid;
        ra  = can && !m_have_a;
        rc  = can && (c_beats.size() < 2);
        rd  = can && !m_have_d;
        check("a_ready", a_ready, ra);
        check("c_ready", c_ready, rc);
        check("d_ready", d_ready, rd);
        check("e_valid", e_valid, m_out_valid);
        check("e_hdr", e_hdr, m_hdr);
        if (m_out_valid) check("e_data", e_data, m_out_data);
        a_valid = av; a_data = ad;
        c_valid = cv; c_data = cd;
        d_valid = dv; d_data = dd;
        e_ready = er;
        if (av && ra) begin m_have_a = 1'b1; m_a = ad[0]; end
        if (cv && rc) c_beats.push_back(cd);
        if (dv && rd) begin m_have_d = 1'b1; m_d = dd; end
        done    = m_have_a && m_have_d && (c_beats.size() == 2);
        consume = m_out_valid && er;
        if (consume) begin
            m_hdr       = m_hdr + 2'd1;
            m_out_valid = 1'b0;
        end
        if (done && !m_out_valid) begin
            m_out_data  = {m_a, m_d, c_beats[1], c_beats[0]};
            m_out_valid = 1'b1;
            m_have_a    = 1'b0;
            m_have_d    = 1'b0;
            c_beats.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge: assert reset between edges, check, release.
    task automatic do_reset();
        a_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0; e_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_e_valid", e_valid, 1'b0);
        check("rst_e_data", e_data, 18'd0);
        check("rst_e_hdr", e_hdr, SEQ);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        a_valid = 1'b0; a_data = 2'd0;
        c_valid = 1'b0; c_data = 5'd0;
        d_valid = 1'b0; d_data = 7'd0;
        e_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Same-cycle beats, then the second c beat.
        step(1'b1, 2'b01, 1'b1, 5'b10101, 1'b1, 7'b0111100, 1'b1);
        step(1'b0, 2'b00, 1'b1, 5'b01010, 1'b0, 7'd0, 1'b1);
        check("same_valid", e_valid, 1'b1);
        check("same_data", e_data, 18'b1_0111100_01010_10101);
        check("same_hdr", e_hdr, 2'd0);
        step(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 7'd0, 1'b1);

        // Out-of-order: d, c, c, a with c_valid held high.
        step(1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 7'h55, 1'b1);
        step(1'b0, 2'b00, 1'b1, 5'h03, 1'b0, 7'd0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 5'h1c, 1'b0, 7'd0, 1'b1);
        check("c_ready_full", c_ready, 1'b0);
        step(1'b1, 2'b10, 1'b1, 5'h1f, 1'b0, 7'd0, 1'b0);
        check("ooo_latency", e_valid, 1'b1);
        check("ooo_data", e_data, {1'b0, 7'h55, 5'h1c, 5'h03});
        check("ooo_hdr", e_hdr, 2'd1);

        // Backpressure for 5 cycles with all inputs offering beats.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b11, 1'b1, 5'h0a, 1'b1, 7'h12, 1'b0);
        end
        check("hold_valid", e_valid, 1'b1);
        check("hold_data", e_data, {1'b0, 7'h55, 5'h1c, 5'h03});
        check("hold_hdr", e_hdr, 2'd1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 7'd0, 1'b1);
        end

        // Reset mid-collection after a and one c beat.
        do_reset();
        step(1'b1, 2'b01, 1'b1, 5'h11, 1'b0, 7'd0, 1'b0);
        do_reset();
        step(1'b0, 2'b00, 1'b1, 5'h06, 1'b0, 7'd0, 1'b1);
        step(1'b1, 2'b00, 1'b1, 5'h19, 1'b1, 7'h7f, 1'b1);
        check("post_rst_valid", e_valid, 1'b1);
        check("post_rst_data", e_data, {1'b0, 7'h7f, 5'h19, 5'h06});
        check("post_rst_hdr", e_hdr, 2'd0);

        // Back-to-back records with e_ready high: header wraps 3 -> 0.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2'($urandom), 1'b1, 5'($urandom), 1'b1, 7'($urandom), 1'b1);
        end

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom),
                 $urandom_range(0, 3) != 0, 5'($urandom),
                 $urandom_range(0, 3) != 0, 7'($urandom),
                 $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
